// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
// Frame-width helper, R/W bit position, FSM states, register map.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    // R/W is the first bit on the wire (frame bit 0, 1 = write)
    localparam int RW_BIT = 0;

    localparam int EN_OUT_LO = 0;
    localparam int EN_OUT_HI = 1;
    localparam int EN_PWM_LO = 2;
    localparam int EN_PWM_HI = 3;
    localparam int PWM_DUTY  = 4;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for sclk/copi/ncs plus sclk and ncs edge pulses.
// Ports: clk, reset, raw inputs in; copi_sync, ncs_sync, edge pulses out.
module spi_sync_edge
    import spi_regfile_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_in,
    input  logic copi_in,
    input  logic ncs_in,
    output logic copi_sync,
    output logic ncs_sync,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ncs_rise,
    output logic ncs_fall
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] copi_ff;
    logic [SYNC_STAGES-1:0] ncs_ff;
    logic                   sclk_prev;
    logic                   ncs_prev;

    // ncs resets low so a frame already in progress at reset
    // release produces no falling edge and is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_ff   <= '0;
            copi_ff   <= '0;
            ncs_ff    <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk_in};
            copi_ff   <= {copi_ff[SYNC_STAGES-2:0], copi_in};
            ncs_ff    <= {ncs_ff[SYNC_STAGES-2:0], ncs_in};
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
            ncs_prev  <= ncs_ff[SYNC_STAGES-1];
        end
    end

    assign copi_sync = copi_ff[SYNC_STAGES-1];
    assign ncs_sync  = ncs_ff[SYNC_STAGES-1];
    assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_prev;
    assign ncs_rise  = ncs_ff[SYNC_STAGES-1] & ~ncs_prev;
    assign ncs_fall  = ~ncs_ff[SYNC_STAGES-1] & ncs_prev;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral with read/write register file and abort counter.
// Ports: clk, reset, SPI pins in; cipo/cipo_oe, regs_flat, wr_*, err_count.
module spi_regfile_periph
    import spi_regfile_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk_in,
    input  logic                         copi_in,
    input  logic                         ncs_in,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   err_count
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int RW_IDX  = ADDR_W - RW_BIT;

    logic copi_sync, ncs_sync;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .copi_in   (copi_in),
        .ncs_in    (ncs_in),
        .copi_sync (copi_sync),
        .ncs_sync  (ncs_sync),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ncs_rise  (ncs_rise),
        .ncs_fall  (ncs_fall)
    );

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W:0]     cmd_sh;
    logic [DATA_W-1:0]   data_sh;
    logic [DATA_W-1:0]   tx_sh;
    logic                rw;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W:0]     cmd_next;
    logic [DATA_W-1:0]   data_next;
    logic [DATA_W-1:0]   rd_data;
    logic                hit;

    assign cmd_next  = {cmd_sh[ADDR_W-1:0], copi_sync};
    assign data_next = {data_sh[DATA_W-2:0], copi_sync};

    // Read lookup on the address being completed; hit flags an
    // in-range latched address for the write commit.
    always_comb begin
        rd_data = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[ADDR_W-1:0] == ADDR_W'(i))
                rd_data = regs[i];
            if (addr == ADDR_W'(i))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_sh    <= '0;
            data_sh   <= '0;
            tx_sh     <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err_count <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            cipo_oe   <= ~ncs_sync;
            cipo      <= (state == DATA) ? tx_sh[DATA_W-1] : 1'b0;
            unique case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state   <= CMD;
                        cnt     <= '0;
                        cmd_sh  <= '0;
                        data_sh <= '0;
                    end
                end
                CMD: begin
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end else if (sclk_rise) begin
                        cmd_sh <= cmd_next;
                        if (cnt == CNT_W'(ADDR_W)) begin
                            rw    <= cmd_next[RW_IDX];
                            addr  <= cmd_next[ADDR_W-1:0];
                            tx_sh <= cmd_next[RW_IDX] ? '0 : rd_data;
                            cnt   <= '0;
                            state <= DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    // an nCS rise in the same clk as the last
                    // sclk rise wins: the frame is aborted
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end else if (sclk_rise) begin
                        data_sh <= data_next;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= DONE;
                            if (rw && hit) begin
                                for (int i = 0; i < NUM_REGS; i++)
                                    if (addr == ADDR_W'(i))
                                        regs[i] <= data_next;
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sclk_fall && cnt != '0) begin
                        // the fall right after the address keeps
                        // the MSB until the first data rise
                        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    if (ncs_rise)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed self-checking bench for spi_regfile_periph.
// Read data is scoreboarded bit by bit against a register model.
module tb_spi_regfile_periph;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 5;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       sclk_in;
    logic                       copi_in;
    logic                       ncs_in;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic [7:0]                 err_count;

    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    int         s0;
    logic [7:0] mdl [NUM_REGS];
    bit         exp_q [$];
    logic [7:0] rd_byte;

    spi_regfile_periph #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .copi_in   (copi_in),
        .ncs_in    (ncs_in),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (wr_strobe === 1'b1)
            strobes++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] mflat();
        logic [NUM_REGS*DATA_W-1:0] r;
        for (int i = 0; i < NUM_REGS; i++)
            r[i*DATA_W +: DATA_W] = mdl[i];
        return r;
    endfunction

    // One sclk pulse per bit; cipo is sampled just before each
    // data-phase rise, i.e. where a mode-0 controller samples it.
    task automatic send_bits(input logic [15:0] frame, input int nbits);
        logic [15:0] f;
        bit          e;
        f = frame;
        for (int i = 0; i < nbits; i++) begin
            copi_in = f[15];
            f = f << 1;
            #50;
            if (i >= 8 && i < 16 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                rd_byte = {rd_byte[6:0], cipo};
                chk($sformatf("cipo_bit%0d", i - 8), cipo, e);
            end
            sclk_in = 1'b1;
            #50;
            sclk_in = 1'b0;
        end
        copi_in = 1'b0;
    endtask

    task automatic frame(input bit rw, input int addr,
                         input logic [7:0] data, input int nbits);
        logic [7:0] e;
        if (!rw) begin
            e = (addr < NUM_REGS) ? mdl[addr] : 8'h00;
            for (int b = 7; b >= 0; b--)
                exp_q.push_back(e[b]);
            rd_byte = '0;
        end
        ncs_in = 1'b0;
        #100;
        chk("cipo_oe_active", cipo_oe, 1'b1);
        send_bits({rw, 7'(addr), data}, nbits);
        #100;
        ncs_in = 1'b1;
        #200;
        chk("cipo_oe_idle", cipo_oe, 1'b0);
        if (rw && nbits >= 16 && addr < NUM_REGS)
            mdl[addr] = data;
    endtask

    initial begin
        reset   = 1'b1;
        sclk_in = 1'b0;
        copi_in = 1'b0;
        ncs_in  = 1'b1;
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++)
            mdl[i] = '0;
        #30;
        chk("rst_regs", regs_flat, '0);
        chk("rst_cipo", cipo, 1'b0);
        chk("rst_cipo_oe", cipo_oe, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, '0);
        chk("rst_err", err_count, 8'd0);
        #20;
        reset = 1'b0;
        #100;

        s0 = strobes;
        frame(1'b1, 4, 8'h80, 16);
        chk("w4_strobes", strobes - s0, 1);
        chk("w4_wr_addr", wr_addr, 4);
        chk("w4_reg4", regs_flat[39:32], 8'h80);
        chk("w4_regs", regs_flat, mflat());

        frame(1'b1, 2, 8'hA5, 16);
        frame(1'b0, 2, 8'h00, 16);
        chk("r2_byte", rd_byte, 8'hA5);
        chk("r2_regs", regs_flat, mflat());

        s0 = strobes;
        frame(1'b1, 0, 8'h77, 10);
        chk("abort_strobes", strobes - s0, 0);
        chk("abort_regs", regs_flat, mflat());
        chk("abort_err", err_count, 8'd1);

        s0 = strobes;
        frame(1'b1, 9, 8'hFF, 16);
        frame(1'b0, 9, 8'h00, 16);
        chk("oor_rd", rd_byte, 8'h00);
        chk("oor_strobes", strobes - s0, 0);
        chk("oor_regs", regs_flat, mflat());
        chk("oor_err", err_count, 8'd1);
        chk("oor_wr_addr", wr_addr, 2);

        for (int k = 0; k < 254; k++)
            frame(1'b1, 0, 8'h00, 2);
        chk("err_255", err_count, 8'd255);
        frame(1'b1, 0, 8'h00, 2);
        chk("err_sat", err_count, 8'd255);

        ncs_in = 1'b0;
        #100;
        send_bits({1'b1, 7'd1, 8'h5A}, 12);
        reset = 1'b1;
        #30;
        for (int i = 0; i < NUM_REGS; i++)
            mdl[i] = '0;
        chk("mid_rst_regs", regs_flat, '0);
        chk("mid_rst_err", err_count, 8'd0);
        chk("mid_rst_wr_addr", wr_addr, '0);
        chk("mid_rst_strobe", wr_strobe, 1'b0);
        chk("mid_rst_cipo_oe", cipo_oe, 1'b0);
        chk("mid_rst_cipo", cipo, 1'b0);
        reset = 1'b0;
        #100;
        s0 = strobes;
        send_bits({1'b1, 7'd1, 8'h5A}, 16);
        #100;
        ncs_in = 1'b1;
        #200;
        chk("stale_strobes", strobes - s0, 0);
        chk("stale_regs", regs_flat, '0);
        chk("stale_err", err_count, 8'd0);

        s0 = strobes;
        frame(1'b1, 1, 8'h5A, 16);
        chk("w1_strobes", strobes - s0, 1);
        chk("w1_wr_addr", wr_addr, 1);
        chk("w1_regs", regs_flat, mflat());

        s0 = strobes;
        frame(1'b1, 3, 8'h3C, 20);
        chk("w3_strobes", strobes - s0, 1);
        chk("w3_reg3", regs_flat[31:24], 8'h3C);
        chk("w3_regs", regs_flat, mflat());
        chk("w3_err", err_count, 8'd0);

        frame(1'b0, 3, 8'h00, 16);
        chk("r3_byte", rd_byte, 8'h3C);
        frame(1'b0, 1, 8'h00, 16);
        chk("r1_byte", rd_byte, 8'h5A);
        chk("q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
